// File: rtl/gpio_seq.sv
// Table-driven write sequencer: replays up to DEPTH programmed {addr, data, delay}
// steps into the gpio register port with cycle-exact spacing, once or looping.
module gpio_seq #(
    parameter int DEPTH = 8,
    parameter int DLY_W = 16
) (
    input  logic        mem_clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        gpio_valid,
    output logic [3:0]  gpio_addr,
    output logic [31:0] gpio_wdata,
    output logic [3:0]  gpio_wstrb,
    input  logic        gpio_ready
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LEN_MAX = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s, adv_state_s;
    logic [IDX_W-1:0]   idx_r, idx_nxt_s, adv_idx_s;
    logic [DLY_W-1:0]   cnt_r, cnt_nxt_s;
    logic               done_r, done_nxt_s, adv_done_s;

    logic [4:0]         len_r;
    logic [IDX_W-1:0]   wptr_r;
    logic               loop_r;
    logic [3:0]         cfg_addr_r;
    logic [DLY_W-1:0]   cfg_dly_r;

    logic [3:0]         tbl_addr_r [DEPTH];
    logic [31:0]        tbl_data_r [DEPTH];
    logic [DLY_W-1:0]   tbl_dly_r  [DEPTH];

    logic               gpio_valid_r, gpio_valid_nxt_s;
    logic [3:0]         gpio_addr_r, gpio_addr_nxt_s;
    logic [31:0]        gpio_wdata_r, gpio_wdata_nxt_s;
    logic [31:0]        rdata_s;

    logic               wr_s, start_s, stop_s, busy_s, last_s, tbl_we_s;
    logic [4:0]         len_sat_s;
    logic [DLY_W-1:0]   cur_dly_s;

    assign wr_s      = mem_valid && (mem_wstrb == 4'hF);
    assign stop_s    = wr_s && (mem_addr == 4'd0) && mem_wdata[1];
    assign start_s   = wr_s && (mem_addr == 4'd0) && mem_wdata[0] && !mem_wdata[1];
    assign busy_s    = (state_r != ST_IDLE);
    assign last_s    = (5'(idx_r) == (len_r - 5'd1));
    assign cur_dly_s = tbl_dly_r[idx_r];
    assign len_sat_s = (mem_wdata[4:0] > LEN_MAX) ? LEN_MAX : mem_wdata[4:0];
    assign tbl_we_s  = wr_s && (mem_addr == 4'd5) && !busy_s && !rst;

    // Slave-side configuration registers; table setup is frozen while a run is active
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            len_r      <= 5'd0;
            wptr_r     <= '0;
            loop_r     <= 1'b0;
            cfg_addr_r <= 4'd0;
            cfg_dly_r  <= '0;
        end else if (wr_s) begin
            case (mem_addr)
                4'd0: loop_r <= mem_wdata[2];
                4'd2: if (!busy_s) len_r <= len_sat_s;
                4'd3: if (!busy_s) wptr_r <= mem_wdata[IDX_W-1:0];
                4'd4: if (!busy_s) begin
                    cfg_addr_r <= mem_wdata[3:0];
                    cfg_dly_r  <= mem_wdata[16 +: DLY_W];
                end
                4'd5: if (!busy_s) wptr_r <= wptr_r + IDX_W'(1'b1);
                default: ;
            endcase
        end
    end

    // Step table storage, intentionally not reset
    always_ff @(posedge mem_clk) begin
        if (tbl_we_s) begin
            tbl_addr_r[wptr_r] <= cfg_addr_r;
            tbl_data_r[wptr_r] <= mem_wdata;
            tbl_dly_r[wptr_r]  <= cfg_dly_r;
        end
    end

    // Sequencer state register
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // End-of-step decision: next entry, wrap when looping, or finish
    always_comb begin
        if (!last_s) begin
            adv_state_s = ST_ISSUE;
            adv_idx_s   = idx_r + IDX_W'(1'b1);
            adv_done_s  = done_r;
        end else if (loop_r) begin
            adv_state_s = ST_ISSUE;
            adv_idx_s   = '0;
            adv_done_s  = done_r;
        end else begin
            adv_state_s = ST_IDLE;
            adv_idx_s   = idx_r;
            adv_done_s  = 1'b1;
        end
    end

    // Next-state logic; a zero delay skips WAIT so handshakes land delay+1 cycles apart
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && (len_r == 5'd0)) begin
                    done_nxt_s = 1'b1;
                end else if (start_s) begin
                    done_nxt_s  = 1'b0;
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (gpio_ready && (cur_dly_s == '0)) begin
                    state_nxt_s = adv_state_s;
                    idx_nxt_s   = adv_idx_s;
                    done_nxt_s  = adv_done_s;
                end else if (gpio_ready) begin
                    cnt_nxt_s   = cur_dly_s - DLY_W'(1'b1);
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == '0) begin
                    state_nxt_s = adv_state_s;
                    idx_nxt_s   = adv_idx_s;
                    done_nxt_s  = adv_done_s;
                end else begin
                    cnt_nxt_s = cnt_r - DLY_W'(1'b1);
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Master outputs computed from the upcoming state so they can be registered
    always_comb begin
        if (state_nxt_s == ST_ISSUE) begin
            gpio_valid_nxt_s = 1'b1;
            gpio_addr_nxt_s  = tbl_addr_r[idx_nxt_s];
            gpio_wdata_nxt_s = tbl_data_r[idx_nxt_s];
        end else begin
            gpio_valid_nxt_s = 1'b0;
            gpio_addr_nxt_s  = 4'd0;
            gpio_wdata_nxt_s = 32'd0;
        end
    end

    // Master output register
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            gpio_valid_r <= 1'b0;
            gpio_addr_r  <= 4'd0;
            gpio_wdata_r <= 32'd0;
        end else begin
            gpio_valid_r <= gpio_valid_nxt_s;
            gpio_addr_r  <= gpio_addr_nxt_s;
            gpio_wdata_r <= gpio_wdata_nxt_s;
        end
    end

    // Slave read mux
    always_comb begin
        rdata_s = 32'd0;
        if (mem_valid) begin
            case (mem_addr)
                4'd1:    rdata_s = {20'd0, 4'(idx_r), 5'd0, loop_r, done_r, busy_s};
                4'd2:    rdata_s = {27'd0, len_r};
                4'd3:    rdata_s = 32'(wptr_r);
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign mem_ready  = mem_valid;
    assign mem_rdata  = rdata_s;
    assign gpio_valid = gpio_valid_r;
    assign gpio_addr  = gpio_addr_r;
    assign gpio_wdata = gpio_wdata_r;
    assign gpio_wstrb = gpio_valid_r ? 4'hF : 4'h0;

endmodule

// File: tb/tb_gpio_seq.sv
// Scoreboard bench for gpio_seq: expected gpio writes (with handshake cycle) are
// queued when a run is started and checked by a monitor at each handshake.
module tb_gpio_seq;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        gpio_valid;
    logic [3:0]  gpio_addr;
    logic [31:0] gpio_wdata;
    logic [3:0]  gpio_wstrb;
    logic        gpio_ready;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          edge_n;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t0;
    logic [31:0] rd;

    gpio_seq #(.DEPTH(8), .DLY_W(16)) dut (
        .mem_clk    (mem_clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .gpio_valid (gpio_valid),
        .gpio_addr  (gpio_addr),
        .gpio_wdata (gpio_wdata),
        .gpio_wstrb (gpio_wstrb),
        .gpio_ready (gpio_ready)
    );

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void sb_push(input logic [3:0] a, input logic [31:0] d, input int e);
        exp_t x;
        x.addr   = a;
        x.data   = d;
        x.edge_n = e;
        sb_q.push_back(x);
    endfunction

    task automatic mem_wr(input logic [3:0] a, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = 4'hF;
        @(posedge mem_clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic mem_rd(input logic [3:0] a, output logic [31:0] d);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = 4'h0;
        @(negedge mem_clk);
        d = mem_rdata;
        check_val("mem_ready", 32'(mem_ready), 32'd1);
        @(posedge mem_clk);
        #1;
        mem_valid = 1'b0;
    endtask

    task automatic prog(input int i, input logic [3:0] a, input logic [31:0] d, input logic [15:0] dly);
        mem_wr(4'd3, 32'(i));
        mem_wr(4'd4, {dly, 12'd0, a});
        mem_wr(4'd5, d);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge mem_clk);
            #1;
            n++;
        end
        check_val(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: no request without a queued expectation, stable request while stalled,
    // and each handshake matches the queue head in content and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge mem_clk);
            if (sb_q.size() == 0) begin
                check_val("idle_valid", 32'(gpio_valid), 32'd0);
            end else if (gpio_valid && !gpio_ready) begin
                check_val("stall_addr", 32'(gpio_addr), 32'(sb_q[0].addr));
                check_val("stall_data", gpio_wdata, sb_q[0].data);
            end else if (gpio_valid && gpio_ready) begin
                e = sb_q.pop_front();
                check_val("hs_addr", 32'(gpio_addr), 32'(e.addr));
                check_val("hs_data", gpio_wdata, e.data);
                check_val("hs_wstrb", 32'(gpio_wstrb), 32'hF);
                check_val("hs_cycle", 32'(cyc + 1), 32'(e.edge_n));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        mem_valid  = 1'b0;
        mem_addr   = 4'd0;
        mem_wdata  = 32'd0;
        mem_wstrb  = 4'h0;
        gpio_ready = 1'b1;
        repeat (2) @(posedge mem_clk);
        #1;
        rst = 1'b0;

        check_val("rst_valid", 32'(gpio_valid), 32'd0);
        check_val("rst_wstrb", 32'(gpio_wstrb), 32'd0);
        check_val("rst_addr", 32'(gpio_addr), 32'd0);
        check_val("rst_wdata", gpio_wdata, 32'd0);
        check_val("idle_ready", 32'(mem_ready), 32'd0);
        check_val("idle_rdata", mem_rdata, 32'd0);
        mem_rd(4'd1, rd); check_val("rst_status", rd, 32'd0);
        mem_rd(4'd2, rd); check_val("rst_len", rd, 32'd0);
        mem_rd(4'd3, rd); check_val("rst_wptr", rd, 32'd0);
        mem_rd(4'd0, rd); check_val("rd_ctrl_wo", rd, 32'd0);

        // single pass, mixed delays
        prog(0, 4'd0, 32'h1, 16'd2);
        prog(1, 4'd1, 32'h2, 16'd0);
        prog(2, 4'd2, 32'h1, 16'd5);
        mem_wr(4'd2, 32'd3);
        t0 = cyc + 1;
        sb_push(4'd0, 32'h1, t0 + 1);
        sb_push(4'd1, 32'h2, t0 + 4);
        sb_push(4'd2, 32'h1, t0 + 5);
        mem_wr(4'd0, 32'h1);
        repeat (11) @(posedge mem_clk);
        #1;
        mem_rd(4'd1, rd);
        check_val("t1_status", {30'd0, rd[1:0]}, 32'd2);
        wait_drain("t1_drain");

        // looping, zero delays, STOP while ISSUE with ready high
        prog(0, 4'd3, 32'hA, 16'd0);
        prog(1, 4'd4, 32'hB, 16'd0);
        mem_wr(4'd2, 32'd2);
        t0 = cyc + 1;
        for (int i = 1; i <= 6; i++) begin
            if (i % 2 == 1) sb_push(4'd3, 32'hA, t0 + i);
            else            sb_push(4'd4, 32'hB, t0 + i);
        end
        mem_wr(4'd0, 32'h5);
        mem_rd(4'd1, rd);
        check_val("t2_status_run", rd, 32'h5);
        repeat (4) @(posedge mem_clk);
        #1;
        mem_wr(4'd0, 32'h2);
        check_val("t2_stop_valid", 32'(gpio_valid), 32'd0);
        mem_rd(4'd1, rd);
        check_val("t2_stop_status", {30'd0, rd[1:0]}, 32'd0);
        wait_drain("t2_drain");

        // START with LEN=0
        mem_wr(4'd2, 32'd0);
        mem_wr(4'd0, 32'h1);
        check_val("t5_len0_valid", 32'(gpio_valid), 32'd0);
        mem_rd(4'd1, rd);
        check_val("t5_len0_status", {30'd0, rd[1:0]}, 32'd2);

        // ready stalled for 4 cycles in ISSUE
        prog(0, 4'd5, 32'h55, 16'd1);
        prog(1, 4'd6, 32'h66, 16'd0);
        mem_wr(4'd2, 32'd2);
        gpio_ready = 1'b0;
        t0 = cyc + 1;
        sb_push(4'd5, 32'h55, t0 + 5);
        sb_push(4'd6, 32'h66, t0 + 7);
        mem_wr(4'd0, 32'h1);
        repeat (4) @(posedge mem_clk);
        #1;
        gpio_ready = 1'b1;
        wait_drain("t3_drain");

        // STOP during WAIT
        prog(0, 4'd5, 32'h55, 16'd10);
        t0 = cyc + 1;
        sb_push(4'd5, 32'h55, t0 + 1);
        mem_wr(4'd0, 32'h1);
        @(posedge mem_clk);
        #1;
        mem_wr(4'd0, 32'h2);
        mem_rd(4'd1, rd);
        check_val("t3b_status", {30'd0, rd[1:0]}, 32'd0);
        repeat (15) @(posedge mem_clk);
        #1;
        check_val("t3b_drain", 32'(sb_q.size()), 32'd0);

        // writes and START while busy are ignored
        prog(0, 4'd7, 32'h70, 16'd6);
        prog(1, 4'd8, 32'h80, 16'd0);
        mem_wr(4'd2, 32'd2);
        t0 = cyc + 1;
        sb_push(4'd7, 32'h70, t0 + 1);
        sb_push(4'd8, 32'h80, t0 + 8);
        mem_wr(4'd0, 32'h1);
        mem_wr(4'd2, 32'd1);
        mem_wr(4'd3, 32'd1);
        mem_wr(4'd4, 32'h0000_000F);
        mem_wr(4'd5, 32'hDEAD);
        mem_wr(4'd0, 32'h1);
        wait_drain("t4_drain");
        mem_rd(4'd2, rd); check_val("t4_len", rd, 32'd2);
        mem_rd(4'd3, rd); check_val("t4_wptr", rd, 32'd2);
        mem_wr(4'd0, 32'h3);
        mem_rd(4'd1, rd);
        check_val("t4_startstop_busy", {31'd0, rd[0]}, 32'd0);
        repeat (5) @(posedge mem_clk);
        #1;

        // LEN saturation and WPTR wrap
        mem_wr(4'd2, 32'd31);
        mem_rd(4'd2, rd); check_val("t5_len_sat", rd, 32'd8);
        mem_wr(4'd3, 32'd0);
        for (int i = 0; i < 9; i++) mem_wr(4'd5, 32'(i));
        mem_rd(4'd3, rd); check_val("t5_wptr_wrap", rd, 32'd1);

        // reset pulse mid-WAIT
        prog(0, 4'd9, 32'h99, 16'd10);
        mem_wr(4'd2, 32'd1);
        t0 = cyc + 1;
        sb_push(4'd9, 32'h99, t0 + 1);
        mem_wr(4'd0, 32'h5);
        @(posedge mem_clk);
        #1;
        rst = 1'b1;
        @(posedge mem_clk);
        #1;
        rst = 1'b0;
        check_val("t6_valid", 32'(gpio_valid), 32'd0);
        check_val("t6_wstrb", 32'(gpio_wstrb), 32'd0);
        mem_rd(4'd1, rd); check_val("t6_status", rd, 32'd0);
        mem_rd(4'd2, rd); check_val("t6_len", rd, 32'd0);
        repeat (15) @(posedge mem_clk);
        #1;
        check_val("t6_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
